// File: rtl/crc_framer_if.sv
// -----------------------------------------------------------------------------
// crc_framer_if
//   Bundles the data-path and handshake signals of crc_framer.
//
//   Handshake: a word on din is transferred in a cycle where din_vld and
//   din_rdy are both high. din_first/din_last qualify that word. dout_vld marks
//   a cycle in which dout carries a data or trailer word; the sink has no
//   backpressure on the output side.
//
//   Signals
//     din        word from the readout formatter
//     din_vld    din is valid
//     din_first  word opens a frame
//     din_last   word closes a frame
//     din_rdy    framer accepts a word this cycle
//     dav        data-available flag stamped into every output word
//     dout       word to the output serialiser
//     dout_vld   dout carries a data or trailer word
//     dout_trl   dout is a trailer word
//     frame_err  one-cycle pulse, din_first seen mid-frame
//
//   Modports: master = upstream/sink side, slave = the framer.
// -----------------------------------------------------------------------------
interface crc_framer_if #(
   parameter int OW = 19
) ();
   logic [OW-1:0] din;
   logic          din_vld;
   logic          din_first;
   logic          din_last;
   logic          din_rdy;
   logic          dav;
   logic [OW-1:0] dout;
   logic          dout_vld;
   logic          dout_trl;
   logic          frame_err;

   modport master (
      output din, din_vld, din_first, din_last, dav,
      input  din_rdy, dout, dout_vld, dout_trl, frame_err
   );

   modport slave (
      input  din, din_vld, din_first, din_last, dav,
      output din_rdy, dout, dout_vld, dout_trl, frame_err
   );
endinterface

// File: rtl/crc_framer.sv
// -----------------------------------------------------------------------------
// crc_framer
//   Frame CRC generator for the DAQ output path. Data words pass through with
//   one cycle of latency while an MSB-first LFSR CRC accumulates over bits
//   [DW-1:0] of every word of the frame. After the last word the CRC is sent as
//   NCH = ceil(CW/CK) marker-tagged trailer words; din_rdy is low meanwhile.
//
//   Optional build macro CRC_FRAMER_WCNT_EN: appends one more trailer word
//   carrying the frame's data-word count modulo 2^(DW-5).
//
//   Ports
//     clk          clock
//     rst          asynchronous, active-high reset
//     bus          crc_framer_if.slave (din/din_vld/din_first/din_last/dav in,
//                  din_rdy/dout/dout_vld/dout_trl/frame_err out)
//     dbg_state_o  current FSM state (0 IDLE, 1 DATA, 2 TRAIL)
// -----------------------------------------------------------------------------
module crc_framer #(
   parameter int            OW      = 19,
   parameter int            DW      = 16,
   parameter int            CW      = 22,
   parameter logic [CW-1:0] POLY    = 22'h000003,
   parameter logic [CW-1:0] INIT    = '0,
   parameter int            CK      = 11,
   parameter logic [3:0]    MARK    = 4'hd,
   parameter int            DAV_BIT = 17
) (
   input  logic        clk,
   input  logic        rst,
   crc_framer_if.slave bus,
   output logic [1:0]  dbg_state_o
);

   localparam int NCH = (CW + CK - 1) / CK;
`ifdef CRC_FRAMER_WCNT_EN
   localparam int NTRL = NCH + 1;
   localparam int WCW  = DW - 5;
`else
   localparam int NTRL = NCH;
`endif
   localparam int KW = (NTRL > 1) ? $clog2(NTRL) : 1;

   // Trailer layout needs the marker nibble plus at least one zero bit.
   if (CK > DW - 5) begin : g_ck_check
      $error("crc_framer: CK must not exceed DW-5");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      TRAIL = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   crc_q, crc_d;
   logic [KW-1:0]   k_q, k_d;
   logic [OW-1:0]   dout_q, dout_d;
   logic            vld_q, vld_d;
   logic            trl_q, trl_d;
   logic            err_q, err_d;
`ifdef CRC_FRAMER_WCNT_EN
   logic [WCW-1:0]  wcnt_q, wcnt_d;
`endif

   logic                accept;
   logic                last_trl;
   logic [NCH*CK-1:0]   crc_pad;
   logic [CK-1:0]       chunk;
   logic [OW-1:0]       pass_word;
   logic [OW-1:0]       trl_word;

   assign bus.din_rdy   = (state_q != TRAIL);
   assign accept        = bus.din_vld & bus.din_rdy;
   assign last_trl      = (k_q == KW'(NTRL - 1));
   assign bus.dout      = dout_q;
   assign bus.dout_vld  = vld_q;
   assign bus.dout_trl  = trl_q;
   assign bus.frame_err = err_q;
   assign dbg_state_o   = state_q;

   // Runs the bit-serial LFSR over one word's CRC field, MSB first.
   function automatic logic [CW-1:0] crc_word(input logic [CW-1:0] c_in,
                                              input logic [DW-1:0] w);
      logic [CW-1:0] c;
      logic          t;
      c = c_in;
      for (int i = DW - 1; i >= 0; i--) begin
         t = w[i] ^ c[CW-1];
         c = {c[CW-2:0], 1'b0} ^ (t ? POLY : '0);
      end
      return c;
   endfunction

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DATA: begin
            if (accept) state_d = bus.din_last ? TRAIL : DATA;
         end
         TRAIL: begin
            if (last_trl) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values
   always_comb begin
      // Zero-pad the CRC so the top chunk reads zeros above CW.
      crc_pad = (NCH*CK)'(crc_q);
      chunk   = '0;
      for (int i = 0; i < NCH; i++) begin
         if (k_q == KW'(i)) chunk = crc_pad[i*CK +: CK];
      end

      trl_word              = '0;
      trl_word[DW-1 -: 4]   = MARK;
      trl_word[CK-1:0]      = chunk;
`ifdef CRC_FRAMER_WCNT_EN
      // Count trailer follows the CRC chunks; WCW >= CK so it covers the chunk.
      if (k_q == KW'(NCH)) trl_word[WCW-1:0] = wcnt_q;
`endif
      trl_word[DAV_BIT]     = bus.dav;

      pass_word             = bus.din;
      pass_word[DAV_BIT]    = bus.dav;

      crc_d  = crc_q;
      k_d    = k_q;
      dout_d = pass_word;
      vld_d  = 1'b0;
      trl_d  = 1'b0;
      err_d  = 1'b0;
`ifdef CRC_FRAMER_WCNT_EN
      wcnt_d = wcnt_q;
`endif

      if (state_q == TRAIL) begin
         dout_d = trl_word;
         vld_d  = 1'b1;
         trl_d  = 1'b1;
         k_d    = last_trl ? '0 : k_q + 1'b1;
      end else if (accept) begin
         vld_d = 1'b1;
         // A frame opens in IDLE; din_first mid-frame restarts it.
         if (state_q == IDLE || bus.din_first) begin
            crc_d  = crc_word(INIT, bus.din[DW-1:0]);
`ifdef CRC_FRAMER_WCNT_EN
            wcnt_d = WCW'(1);
`endif
         end else begin
            crc_d  = crc_word(crc_q, bus.din[DW-1:0]);
`ifdef CRC_FRAMER_WCNT_EN
            wcnt_d = wcnt_q + 1'b1;
`endif
         end
         err_d = (state_q == DATA) && bus.din_first;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_q  <= INIT;
         k_q    <= '0;
         dout_q <= '0;
         vld_q  <= 1'b0;
         trl_q  <= 1'b0;
         err_q  <= 1'b0;
`ifdef CRC_FRAMER_WCNT_EN
         wcnt_q <= '0;
`endif
      end else begin
         crc_q  <= crc_d;
         k_q    <= k_d;
         dout_q <= dout_d;
         vld_q  <= vld_d;
         trl_q  <= trl_d;
         err_q  <= err_d;
`ifdef CRC_FRAMER_WCNT_EN
         wcnt_q <= wcnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_crc_framer.sv
// -----------------------------------------------------------------------------
// tb_crc_framer
//   Directed bench for crc_framer with a frame-level reference model. The
//   model computes the CRC as the remainder of polynomial long division over
//   the frame's bit string and predicts the per-cycle outputs; a single
//   compare process checks them. Hand-computed literals pin the model and the
//   key waveforms.
// -----------------------------------------------------------------------------
module tb_crc_framer;

   localparam int            OW      = 19;
   localparam int            DW      = 16;
   localparam int            CW      = 22;
   localparam int            CK      = 11;
   localparam int            DAV_BIT = 17;
   localparam logic [CW-1:0] POLY    = 22'h000003;
   localparam logic [CW-1:0] INIT    = '0;
   localparam logic [3:0]    MARK    = 4'hd;
   localparam int            NCH     = 2;
`ifdef CRC_FRAMER_WCNT_EN
   localparam int            NTRL    = 3;
`else
   localparam int            NTRL    = 2;
`endif
   localparam int            EW      = OW + 4;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   crc_framer_if #(.OW(OW)) bus ();

   crc_framer #(
      .OW(OW), .DW(DW), .CW(CW), .POLY(POLY), .INIT(INIT),
      .CK(CK), .MARK(MARK), .DAV_BIT(DAV_BIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .dbg_state_o(dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int            n_vec    = 0;
   int            n_err    = 0;
   int            n_ferr   = 0;
   int            n_rdy_lo = 0;
   logic [EW-1:0] exp_q[$];
   logic [OW-1:0] obs_q[$];
   logic [DW-1:0] frm_q[$];
   logic [OW-1:0] pend_q[$];
   bit            in_frame = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // CRC as remainder of (INIT*x^n + M(x)*x^CW) mod (x^CW + POLY).
   function automatic logic [CW-1:0] golden_crc(input logic [DW-1:0] ws[$]);
      bit            m[$];
      int            n;
      logic [CW-1:0] r;
      foreach (ws[w]) begin
         for (int b = DW - 1; b >= 0; b--) m.push_back(ws[w][b]);
      end
      n = m.size();
      for (int j = 0; j < CW; j++) m.push_back(1'b0);
      for (int j = 0; j < CW; j++) m[j] ^= INIT[CW-1-j];
      for (int i = 0; i < n; i++) begin
         if (m[i]) begin
            m[i] = 1'b0;
            for (int j = 1; j <= CW; j++) m[i+j] ^= POLY[CW-j];
         end
      end
      r = '0;
      for (int j = 0; j < CW; j++) r[CW-1-j] = m[n+j];
      return r;
   endfunction

   // Predicts the outputs registered at the edge that ends this cycle.
   task automatic model_cycle(input bit vld, input bit first, input bit last,
                              input logic [OW-1:0] word, input bit dv);
      logic [OW-1:0] e_dout;
      logic          e_vld, e_trl, e_err, e_rdy;
      logic [CW-1:0] c;
      logic [63:0]   cc;
      logic [OW-1:0] tw;
      e_err = 1'b0;
      if (pend_q.size() != 0) begin
         e_dout = pend_q.pop_front();
         e_vld  = 1'b1;
         e_trl  = 1'b1;
      end else begin
         e_dout = word;
         e_vld  = vld;
         e_trl  = 1'b0;
         if (vld) begin
            if (in_frame && first) e_err = 1'b1;
            if (!in_frame || first) frm_q.delete();
            frm_q.push_back(word[DW-1:0]);
            in_frame = 1'b1;
            if (last) begin
               c  = golden_crc(frm_q);
               cc = 64'(c);
               for (int k = 0; k < NCH; k++) begin
                  tw                = '0;
                  tw[DW-1 -: 4]     = MARK;
                  tw[CK-1:0]        = CK'(cc >> (k * CK));
                  pend_q.push_back(tw);
               end
`ifdef CRC_FRAMER_WCNT_EN
               tw            = '0;
               tw[DW-1 -: 4] = MARK;
               tw[DW-6:0]    = (DW-5)'(frm_q.size());
               pend_q.push_back(tw);
`endif
               in_frame = 1'b0;
            end
         end
      end
      e_dout[DAV_BIT] = dv;
      e_rdy = (pend_q.size() == 0);
      exp_q.push_back({e_dout, e_vld, e_trl, e_err, e_rdy});
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input bit vld, input bit first, input bit last,
                       input logic [OW-1:0] word, input bit dv);
      @(negedge clk);
      bus.din_vld   = vld;
      bus.din_first = first;
      bus.din_last  = last;
      bus.din       = word;
      bus.dav       = dv;
      model_cycle(vld, first, last, word, dv);
   endtask

   task automatic idle(input int n, input bit dv);
      repeat (n) step(1'b0, 1'b0, 1'b0, OW'($urandom_range(0, 524287)), dv);
   endtask

   // Drives valid junk while the framer is in TRAIL; it must be ignored.
   task automatic junk(input int n);
      repeat (n) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      OW'($urandom_range(0, 524287)), 1'b1);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic lit(input string name, input int idx, input logic [OW-1:0] exp);
      check(name, (idx < obs_q.size()) ? 32'(obs_q[idx]) : 32'hFFFF_FFFF, 32'(exp));
   endtask

   task automatic new_test();
      obs_q.delete();
      n_rdy_lo = 0;
      n_ferr   = 0;
   endtask

   // ---------------- compare process ----------------
   initial begin : compare
      logic [EW-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("dout",      32'(bus.dout),      32'(e[EW-1 -: OW]));
            check("dout_vld",  32'(bus.dout_vld),  32'(e[3]));
            check("dout_trl",  32'(bus.dout_trl),  32'(e[2]));
            check("frame_err", 32'(bus.frame_err), 32'(e[1]));
            check("din_rdy",   32'(bus.din_rdy),   32'(e[0]));
            if (bus.dout_vld)  obs_q.push_back(bus.dout);
            if (bus.frame_err) n_ferr++;
            if (!bus.din_rdy)  n_rdy_lo++;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin : main
      logic [DW-1:0] tq[$];
      int            nw;

      bus.din = '0; bus.din_vld = 1'b0; bus.din_first = 1'b0;
      bus.din_last = 1'b0; bus.dav = 1'b0;

      // Model pins: hand-divided remainders.
      tq = {16'h0001};
      check("model_crc_0001", 32'(golden_crc(tq)), 32'h0000_0003);
      tq = {16'h8000};
      check("model_crc_8000", 32'(golden_crc(tq)), 32'h0001_8000);
      tq = {16'h0001, 16'h0000, 16'h0000};
      check("model_crc_3w",   32'(golden_crc(tq)), 32'h0000_1400);

      // Reset state
      #2 rst = 1'b1;
      bus.din = 19'h7ffff;
      #2;
      check("rst_dout",  32'(bus.dout),      32'h0);
      check("rst_vld",   32'(bus.dout_vld),  32'h0);
      check("rst_trl",   32'(bus.dout_trl),  32'h0);
      check("rst_err",   32'(bus.frame_err), 32'h0);
      check("rst_rdy",   32'(bus.din_rdy),   32'h1);
      check("rst_state", 32'(dbg_state),     32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Single word 0x00001, dav=1
      new_test();
      step(1'b1, 1'b1, 1'b1, 19'h00001, 1'b1);
      idle(NTRL + 1, 1'b1);
      settle();
      lit("t1_data", 0, 19'h20001);
      lit("t1_trl0", 1, 19'h2D003);
      lit("t1_trl1", 2, 19'h2D000);
      check("t1_rdy_low", 32'(n_rdy_lo), 32'(NTRL));

      // Single word 0x08000, dav=0
      new_test();
      step(1'b1, 1'b1, 1'b1, 19'h08000, 1'b0);
      idle(NTRL + 1, 1'b0);
      settle();
      lit("t2_data", 0, 19'h08000);
      lit("t2_trl0", 1, 19'h0D000);
      lit("t2_trl1", 2, 19'h0D030);

      // Three words with valid gaps; junk driven during TRAIL
      new_test();
      step(1'b1, 1'b1, 1'b0, 19'h00001, 1'b1);
      idle(2, 1'($urandom_range(0, 1)));
      step(1'b1, 1'b0, 1'b0, 19'h00000, 1'b1);
      idle(1, 1'($urandom_range(0, 1)));
      step(1'b1, 1'b0, 1'b1, 19'h00000, 1'b1);
      junk(NTRL);
      idle(2, 1'b1);
      settle();
      lit("t3_w0",   0, 19'h20001);
      lit("t3_w1",   1, 19'h20000);
      lit("t3_w2",   2, 19'h20000);
      lit("t3_trl0", 3, 19'h2D400);
      lit("t3_trl1", 4, 19'h2D002);

      // din_first on word 2 restarts the frame
      new_test();
      step(1'b1, 1'b1, 1'b0, 19'h01234, 1'b1);
      step(1'b1, 1'b1, 1'b0, 19'h00001, 1'b1);
      step(1'b1, 1'b0, 1'b1, 19'h00000, 1'b1);
      idle(NTRL + 1, 1'b1);
      settle();
      check("t4_err_pulses", 32'(n_ferr), 32'h1);
      lit("t4_w0",   0, 19'h21234);
      lit("t4_trl0", 3, 19'h2D000);
      lit("t4_trl1", 4, 19'h2D060);

      // Reset during the trailer; next frame (no din_first) starts clean
      new_test();
      step(1'b1, 1'b1, 1'b1, 19'h01234, 1'b1);
      step(1'b0, 1'b0, 1'b0, 19'h00000, 1'b1);
      @(negedge clk);
      check("t5_state_trail", 32'(dbg_state), 32'h2);
      #1 rst = 1'b1;
      #1;
      check("t5_rst_dout",  32'(bus.dout),      32'h0);
      check("t5_rst_vld",   32'(bus.dout_vld),  32'h0);
      check("t5_rst_trl",   32'(bus.dout_trl),  32'h0);
      check("t5_rst_err",   32'(bus.frame_err), 32'h0);
      check("t5_rst_rdy",   32'(bus.din_rdy),   32'h1);
      check("t5_rst_state", 32'(dbg_state),     32'h0);
      exp_q.delete();
      pend_q.delete();
      frm_q.delete();
      in_frame = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      new_test();
      step(1'b1, 1'b0, 1'b1, 19'h00001, 1'b1);
      idle(NTRL + 1, 1'b1);
      settle();
      lit("t5_data", 0, 19'h20001);
      lit("t5_trl0", 1, 19'h2D003);
      lit("t5_trl1", 2, 19'h2D000);

      // Five-word frame
      new_test();
      for (int w = 0; w < 5; w++) step(1'b1, w == 0, w == 4, OW'(w + 1), 1'b1);
      idle(NTRL + 1, 1'b1);
      settle();
      check("t6_words_out", 32'(obs_q.size()), 32'(5 + NTRL));
      check("t6_rdy_low",   32'(n_rdy_lo),     32'(NTRL));
`ifdef CRC_FRAMER_WCNT_EN
      check("t6_wcnt", (obs_q.size() > 7) ? 32'(obs_q[7][15:0]) : 32'hFFFF_FFFF,
            32'h0000_D005);
`endif

      // A few frames of random data and gaps, model-checked
      for (int f = 0; f < 4; f++) begin
         nw = int'($urandom_range(1, 4));
         for (int w = 0; w < nw; w++) begin
            idle(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            step(1'b1, w == 0, w == nw - 1, OW'($urandom_range(0, 524287)),
                 1'($urandom_range(0, 1)));
         end
         junk(NTRL);
      end
      idle(2, 1'b0);
      settle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
